// File: rtl/led_pattern_engine_if.sv
// LED pattern engine control/status bundle: controller drives mode, period and loads, engine returns pattern and step.
// The controller side (master) drives every control; the engine side (slave) drives leds and step.
interface led_pattern_engine_if #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 24
);
    logic                 enable;
    logic [1:0]           mode;
    logic [DIV_WIDTH-1:0] period;
    logic                 load;
    logic [WIDTH-1:0]     load_pattern;
    logic [WIDTH-1:0]     leds;
    logic                 step;

    modport master (
        output enable, mode, period, load, load_pattern,
        input  leds, step
    );

    modport slave (
        input  enable, mode, period, load, load_pattern,
        output leds, step
    );
endinterface

// File: rtl/led_pattern_engine.sv
// LED pattern sequencer: rotates, bounces or holds a WIDTH-bit pattern once every P_eff enabled clocks.
// Latency: leds and step are registered; the first step lands P_eff edges after reset or load.
// Backpressure: none; enable=0 freezes all state, and load always wins over enable.
module led_pattern_engine #(
    parameter int               WIDTH        = 8,
    parameter int               DIV_WIDTH    = 24,
    parameter logic [WIDTH-1:0] INIT_PATTERN = WIDTH'(8'b0001_1111)
) (
    input  logic                  clk,
    input  logic                  rst,
    led_pattern_engine_if.slave   bus
);

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [1:0]           MODE_ROTL   = 2'b00;
    localparam logic [1:0]           MODE_ROTR   = 2'b01;
    localparam logic [1:0]           MODE_BOUNCE = 2'b10;
    localparam logic [DIV_WIDTH-1:0] CNT_ONE     = DIV_WIDTH'(1);

    logic [WIDTH-1:0]     leds_q, leds_nxt;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_nxt;
    dir_t                 dir_q, dir_nxt;
    logic                 step_q, step_nxt;
    logic [DIV_WIDTH-1:0] p_eff;
    logic                 tick;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    // '>=' rather than '==' so a period cut below the running count ticks at once
    assign p_eff = (bus.period == '0) ? CNT_ONE : bus.period;
    assign tick  = (cnt_q >= (p_eff - CNT_ONE));

    always_comb begin
        leds_nxt = leds_q;
        cnt_nxt  = cnt_q;
        dir_nxt  = dir_q;
        step_nxt = 1'b0;
        if (bus.load) begin
            leds_nxt = bus.load_pattern;
            cnt_nxt  = '0;
            dir_nxt  = DIR_LEFT;
        end else if (bus.enable) begin
            if (tick) begin
                cnt_nxt  = '0;
                step_nxt = 1'b1;
                case (bus.mode)
                    MODE_ROTL: leds_nxt = rotl(leds_q);
                    MODE_ROTR: leds_nxt = rotr(leds_q);
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_LEFT && leds_q[WIDTH-1]) begin
                            dir_nxt  = DIR_RIGHT;
                            leds_nxt = rotr(leds_q);
                        end else if (dir_q == DIR_RIGHT && leds_q[0]) begin
                            dir_nxt  = DIR_LEFT;
                            leds_nxt = rotl(leds_q);
                        end else if (dir_q == DIR_RIGHT) begin
                            leds_nxt = rotr(leds_q);
                        end else begin
                            leds_nxt = rotl(leds_q);
                        end
                    end
                    default: leds_nxt = leds_q;
                endcase
            end else begin
                cnt_nxt = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q <= INIT_PATTERN;
            cnt_q  <= '0;
            dir_q  <= DIR_LEFT;
            step_q <= 1'b0;
        end else begin
            leds_q <= leds_nxt;
            cnt_q  <= cnt_nxt;
            dir_q  <= dir_nxt;
            step_q <= step_nxt;
        end
    end

    assign bus.leds = leds_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: directed scenarios plus random traffic against a behavioural model.
module tb_led_pattern_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_pattern_engine_if #(.WIDTH(8), .DIV_WIDTH(24)) bus();

    led_pattern_engine #(
        .WIDTH(8),
        .DIV_WIDTH(24),
        .INIT_PATTERN(8'h1F)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state: pattern as an integer, clocks counted since the last step, travel direction.
    int m_leds  = 8'h1F;
    int m_cnt   = 0;
    bit m_right = 1'b0;
    bit m_step  = 1'b0;

    function automatic int rot(input int v, input bit right);
        return right ? (((v >> 1) | (v << 7)) & 255) : (((v << 1) | (v >> 7)) & 255);
    endfunction

    // Advance one rising edge, update the model from the inputs seen at that edge, then settle.
    task automatic tick_edge();
        int  peff;
        bit  at_end;
        @(posedge clk);
        if (rst) begin
            m_leds = 8'h1F; m_cnt = 0; m_right = 1'b0; m_step = 1'b0;
        end else if (bus.load) begin
            m_leds = int'(bus.load_pattern); m_cnt = 0; m_right = 1'b0; m_step = 1'b0;
        end else if (!bus.enable) begin
            m_step = 1'b0;
        end else begin
            peff = (bus.period == 0) ? 1 : int'(bus.period);
            if (m_cnt + 1 >= peff) begin
                m_cnt  = 0;
                m_step = 1'b1;
                case (bus.mode)
                    2'd0: m_leds = rot(m_leds, 1'b0);
                    2'd1: m_leds = rot(m_leds, 1'b1);
                    2'd2: begin
                        at_end = m_right ? ((m_leds & 1) != 0) : ((m_leds & 128) != 0);
                        if (at_end) m_right = !m_right;
                        m_leds = rot(m_leds, m_right);
                    end
                    default: ;
                endcase
            end else begin
                m_cnt  = m_cnt + 1;
                m_step = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_load(input logic [7:0] pat);
        bus.load = 1'b1; bus.load_pattern = pat;
        tick_edge();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        bus.enable = 1'b0; bus.mode = 2'd0; bus.period = 24'd2;
        bus.load = 1'b0; bus.load_pattern = 8'h00;
        rst = 1'b1;
        tick_edge();
        tick_edge();
        total++;
        if (bus.leds !== 8'h1F) begin bad++; $display("FAIL reset_leds: got %h expected 1f", bus.leds); end
        total++;
        if (bus.step !== 1'b0) begin bad++; $display("FAIL reset_step: got %b expected 0", bus.step); end
        rst = 1'b0;
    endtask

    task automatic test_rotate_left();
        logic [7:0] exp_leds [8];
        exp_leds = '{8'h1F, 8'h3E, 8'h3E, 8'h7C, 8'h7C, 8'hF8, 8'hF8, 8'hF1};
        bus.enable = 1'b1; bus.mode = 2'd0; bus.period = 24'd2;
        for (int i = 0; i < 8; i++) begin
            tick_edge();
            total++;
            if (bus.leds !== exp_leds[i]) begin
                bad++; $display("FAIL rotl_leds edge %0d: got %h expected %h", i + 1, bus.leds, exp_leds[i]);
            end
            total++;
            if (bus.step !== ((i % 2) == 1)) begin
                bad++; $display("FAIL rotl_step edge %0d: got %b expected %b", i + 1, bus.step, (i % 2) == 1);
            end
        end
    endtask

    task automatic test_rotate_right();
        logic [7:0] exp_l;
        bus.mode = 2'd1; bus.period = 24'd0;
        do_load(8'h80);
        total++;
        if (bus.leds !== 8'h80 || bus.step !== 1'b0) begin
            bad++; $display("FAIL rotr_load: got %h/%b expected 80/0", bus.leds, bus.step);
        end
        for (int i = 1; i <= 12; i++) begin
            bus.period = 24'(i % 2);
            tick_edge();
            exp_l = 8'h80 >> (i % 8);
            total++;
            if (bus.leds !== exp_l) begin
                bad++; $display("FAIL rotr_leds step %0d: got %h expected %h", i, bus.leds, exp_l);
            end
            total++;
            if (bus.step !== 1'b1) begin bad++; $display("FAIL rotr_step step %0d: got %b expected 1", i, bus.step); end
        end
    endtask

    task automatic test_bounce();
        int         pos;
        logic [7:0] exp_l;
        bus.mode = 2'd2; bus.period = 24'd1;
        do_load(8'h01);
        for (int k = 1; k <= 16; k++) begin
            tick_edge();
            pos   = (k <= 7) ? k : ((k <= 14) ? 14 - k : k - 14);
            exp_l = 8'(1 << pos);
            total++;
            if (bus.leds !== exp_l) begin
                bad++; $display("FAIL bounce_walk step %0d: got %h expected %h", k, bus.leds, exp_l);
            end
        end
        do_load(8'h81);
        tick_edge();
        total++;
        if (bus.leds !== 8'hC0) begin bad++; $display("FAIL bounce_81_first: got %h expected c0", bus.leds); end
        for (int k = 0; k < 6; k++) begin
            tick_edge();
            total++;
            if (bus.leds !== m_leds[7:0]) begin
                bad++; $display("FAIL bounce_81 step %0d: got %h expected %h", k, bus.leds, m_leds[7:0]);
            end
        end
        do_load(8'hFF);
        for (int k = 0; k < 4; k++) begin
            tick_edge();
            total++;
            if (bus.leds !== 8'hFF || bus.step !== 1'b1) begin
                bad++; $display("FAIL bounce_ones step %0d: got %h/%b expected ff/1", k, bus.leds, bus.step);
            end
        end
        do_load(8'h00);
        for (int k = 0; k < 4; k++) begin
            tick_edge();
            total++;
            if (bus.leds !== 8'h00 || bus.step !== 1'b1) begin
                bad++; $display("FAIL bounce_zero step %0d: got %h/%b expected 00/1", k, bus.leds, bus.step);
            end
        end
    endtask

    task automatic test_enable_freeze();
        bus.mode = 2'd0; bus.period = 24'd3; bus.enable = 1'b1;
        do_load(8'h11);
        tick_edge();
        bus.enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick_edge();
            total++;
            if (bus.leds !== 8'h11 || bus.step !== 1'b0) begin
                bad++; $display("FAIL freeze cycle %0d: got %h/%b expected 11/0", k, bus.leds, bus.step);
            end
        end
        bus.enable = 1'b1;
        tick_edge();
        total++;
        if (bus.leds !== 8'h11 || bus.step !== 1'b0) begin
            bad++; $display("FAIL resume_first: got %h/%b expected 11/0", bus.leds, bus.step);
        end
        tick_edge();
        total++;
        if (bus.leds !== 8'h22 || bus.step !== 1'b1) begin
            bad++; $display("FAIL resume_tick: got %h/%b expected 22/1", bus.leds, bus.step);
        end
    endtask

    task automatic test_load_priority();
        bus.mode = 2'd0; bus.period = 24'd2; bus.enable = 1'b1;
        do_load(8'h0F);
        tick_edge();
        do_load(8'hA5);
        total++;
        if (bus.leds !== 8'hA5 || bus.step !== 1'b0) begin
            bad++; $display("FAIL load_on_tick: got %h/%b expected a5/0", bus.leds, bus.step);
        end
        tick_edge();
        total++;
        if (bus.step !== 1'b0) begin bad++; $display("FAIL load_gap: got %b expected 0", bus.step); end
        tick_edge();
        total++;
        if (bus.leds !== 8'h4B || bus.step !== 1'b1) begin
            bad++; $display("FAIL load_next_step: got %h/%b expected 4b/1", bus.leds, bus.step);
        end
        bus.enable = 1'b0;
        do_load(8'h3C);
        total++;
        if (bus.leds !== 8'h3C || bus.step !== 1'b0) begin
            bad++; $display("FAIL load_disabled: got %h/%b expected 3c/0", bus.leds, bus.step);
        end
        bus.enable = 1'b1;
        tick_edge();
        tick_edge();
        rst = 1'b1;
        tick_edge();
        rst = 1'b0;
        total++;
        if (bus.leds !== 8'h1F || bus.step !== 1'b0) begin
            bad++; $display("FAIL reset_midrun: got %h/%b expected 1f/0", bus.leds, bus.step);
        end
    endtask

    task automatic test_hold_period_cut();
        bus.mode = 2'd3; bus.period = 24'd10; bus.enable = 1'b1;
        do_load(8'h5A);
        for (int k = 0; k < 6; k++) begin
            tick_edge();
            total++;
            if (bus.step !== 1'b0) begin bad++; $display("FAIL hold_early_step %0d: got %b expected 0", k, bus.step); end
        end
        bus.period = 24'd2;
        tick_edge();
        total++;
        if (bus.leds !== 8'h5A || bus.step !== 1'b1) begin
            bad++; $display("FAIL period_cut_tick: got %h/%b expected 5a/1", bus.leds, bus.step);
        end
        for (int k = 0; k < 4; k++) begin
            tick_edge();
            total++;
            if (bus.leds !== 8'h5A || bus.step !== ((k % 2) == 1)) begin
                bad++; $display("FAIL hold_pulse %0d: got %h/%b expected 5a/%b", k, bus.leds, bus.step, (k % 2) == 1);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rst              = ($urandom % 64) == 0;
            bus.load         = ($urandom % 16) == 0;
            bus.enable       = ($urandom % 8) != 0;
            bus.mode         = 2'($urandom % 4);
            bus.period       = 24'($urandom_range(0, 5));
            bus.load_pattern = 8'($urandom);
            tick_edge();
            total++;
            if (bus.leds !== m_leds[7:0] || bus.step !== m_step) begin
                bad++;
                $display("FAIL random cycle %0d: got %h/%b expected %h/%b", k, bus.leds, bus.step, m_leds[7:0], m_step);
            end
        end
        rst = 1'b0; bus.load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rotate_left();
        test_rotate_right();
        test_bounce();
        test_enable_freeze();
        test_load_priority();
        test_hold_period_cut();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
